regfile_mp_scoreboard: RTL and testbench

Parametrised multi-port successor to the core's integer register file: two write ports, NUM_READ combinational read ports, and optional same-cycle write-to-read bypass. It adds a per-register busy scoreboard so issue logic can stall on operands with outstanding writes. Sits between decode/issue (reads, busy marking) and the two writeback paths (ALU and load).

---
 rtl/regfile_mp_scoreboard.sv | 130 +++++++++++++
 tb/tb_regfile_mp_scoreboard.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_scoreboard.sv
// ============================================================================
// regfile_mp_scoreboard: two-write / N-read register file with busy scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_mp_scoreboard #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32,
  parameter int NUM_READ      = 2,
  parameter int BYPASS        = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr0_en,
  input  logic [ADDRESS_WIDTH-1:0]          wr0_addr,
  input  logic [DATA_WIDTH-1:0]             wr0_data,
  input  logic                              wr1_en,
  input  logic [ADDRESS_WIDTH-1:0]          wr1_addr,
  input  logic [DATA_WIDTH-1:0]             wr1_data,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_READ-1:0]               rd_busy,
  input  logic                              issue_en,
  input  logic [ADDRESS_WIDTH-1:0]          issue_addr,
  output logic [NUM_REGS-1:0]               busy_vec,
  output logic                              wr_conflict
);

  localparam logic [ADDRESS_WIDTH:0] c_num_regs = (ADDRESS_WIDTH+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_busy;
  logic                  r_conflict;
  logic                  w_wr0_ok;
  logic                  w_wr1_ok;

  // A write is effective only for an in-range, non-zero destination; gating
  // with rst_n keeps bypassed reads at zero while reset is held.
  assign w_wr0_ok = rst_n && wr0_en && (wr0_addr != '0) && ({1'b0, wr0_addr} < c_num_regs);
  assign w_wr1_ok = rst_n && wr1_en && (wr1_addr != '0) && ({1'b0, wr1_addr} < c_num_regs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_wr1_ok && (wr1_addr == ADDRESS_WIDTH'(r))) begin
          r_regs[r] <= wr1_data;
        end else if (w_wr0_ok && (wr0_addr == ADDRESS_WIDTH'(r))) begin
          r_regs[r] <= wr0_data;
        end
      end
    end
  end

  // Issue takes priority over writeback: a fresh producer keeps the entry busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue_en && (issue_addr == ADDRESS_WIDTH'(r))) begin
          r_busy[r] <= 1'b1;
        end else if ((w_wr0_ok && (wr0_addr == ADDRESS_WIDTH'(r))) ||
                     (w_wr1_ok && (wr1_addr == ADDRESS_WIDTH'(r)))) begin
          r_busy[r] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_wr0_ok && w_wr1_ok && (wr0_addr == wr1_addr);
    end
  end

  assign busy_vec    = r_busy;
  assign wr_conflict = r_conflict;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
      logic [ADDRESS_WIDTH-1:0] w_addr;
      logic [DATA_WIDTH-1:0]    w_stored;
      logic                     w_stored_busy;
      logic                     w_hit0;
      logic                     w_hit1;
      logic [DATA_WIDTH-1:0]    w_data;

      assign w_addr = rd_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];

      // Index 0 and out-of-range addresses never match, so they read 0 / idle.
      always_comb begin
        w_stored      = '0;
        w_stored_busy = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
          if (w_addr == ADDRESS_WIDTH'(r)) begin
            w_stored      = r_regs[r];
            w_stored_busy = r_busy[r];
          end
        end
      end

      assign w_hit0 = (BYPASS != 0) && w_wr0_ok && (wr0_addr == w_addr);
      assign w_hit1 = (BYPASS != 0) && w_wr1_ok && (wr1_addr == w_addr);

      always_comb begin
        w_data = w_stored;
        if (w_hit1) begin
          w_data = wr1_data;
        end else if (w_hit0) begin
          w_data = wr0_data;
        end
      end

      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = w_data;
      assign rd_busy[gi] = w_stored_busy && !(w_hit0 || w_hit1);
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: three instances (default, no-bypass,
// 4-port/16-reg) share write/issue stimulus and are checked against a model.
`default_nettype none

module tb_regfile_mp_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr0_en, wr1_en, issue_en;
  logic [4:0]  wr0_addr, wr1_addr, issue_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [9:0]  rd_addr2;
  logic [19:0] rd_addr4;

  logic [63:0]  rd_data_a, rd_data_b;
  logic [127:0] rd_data_c;
  logic [1:0]   rd_busy_a, rd_busy_b;
  logic [3:0]   rd_busy_c;
  logic [31:0]  busy_a, busy_b;
  logic [15:0]  busy_c;
  logic         conf_a, conf_b, conf_c;

  int n_checks = 0;
  int n_fail   = 0;

  // model: index 0 tracks the 32-register instances, index 1 the 16-register one
  logic [31:0] m_reg  [2][32];
  bit          m_busy [2][32];
  bit          m_conf [2];

  always #5 clk = ~clk;

  regfile_mp_scoreboard #(.NUM_READ(2), .NUM_REGS(32), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr2), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .busy_vec(busy_a), .wr_conflict(conf_a));

  regfile_mp_scoreboard #(.NUM_READ(2), .NUM_REGS(32), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr2), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .busy_vec(busy_b), .wr_conflict(conf_b));

  regfile_mp_scoreboard #(.NUM_READ(4), .NUM_REGS(16), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr4), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .busy_vec(busy_c), .wr_conflict(conf_c));

  function automatic int nregs(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic bit valid_dst(int k, logic [4:0] a);
    return (a != 0) && (int'(a) < nregs(k));
  endfunction

  function automatic logic [31:0] exp_rd(int k, bit byp, logic [4:0] a);
    if (!valid_dst(k, a)) return 32'h0;
    if (byp && wr1_en && wr1_addr == a) return wr1_data;
    if (byp && wr0_en && wr0_addr == a) return wr0_data;
    return m_reg[k][a];
  endfunction

  function automatic bit exp_busy(int k, bit byp, logic [4:0] a);
    if (!valid_dst(k, a)) return 1'b0;
    if (byp && ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a))) return 1'b0;
    return m_busy[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 32; a++) begin
        m_reg[k][a]  = 32'h0;
        m_busy[k][a] = 1'b0;
      end
      m_conf[k] = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    wr0_en = 0; wr1_en = 0; issue_en = 0;
    wr0_addr = 0; wr1_addr = 0; issue_addr = 0;
    wr0_data = 0; wr1_data = 0;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    bit e0 = wr0_en, e1 = wr1_en, ie = issue_en;
    logic [4:0] a0 = wr0_addr, a1 = wr1_addr, ia = issue_addr;
    logic [31:0] d0 = wr0_data, d1 = wr1_data;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      bit v0 = e0 && valid_dst(k, a0);
      bit v1 = e1 && valid_dst(k, a1);
      if (v0) begin m_reg[k][a0] = d0; m_busy[k][a0] = 1'b0; end
      if (v1) begin m_reg[k][a1] = d1; m_busy[k][a1] = 1'b0; end
      if (ie && valid_dst(k, ia)) m_busy[k][ia] = 1'b1;
      m_conf[k] = v0 && v1 && (a0 == a1);
    end
    #1;
  endtask

  task automatic test_reset();
    clear_inputs(); rd_addr2 = {5'd5, 5'd5}; rd_addr4 = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    n_checks++; if (rd_data_a !== 64'h0) begin n_fail++; $display("FAIL reset_rd got %h want 0", rd_data_a); end
    n_checks++; if (busy_a !== 32'h0 || busy_c !== 16'h0) begin n_fail++; $display("FAIL reset_busy got %h/%h want 0", busy_a, busy_c); end
    n_checks++; if (conf_a !== 1'b0) begin n_fail++; $display("FAIL reset_conf got %b want 0", conf_a); end
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEAD_BEEF;
    wr1_en = 1; wr1_addr = 5; wr1_data = 32'hDEAD_BEEF;
    issue_en = 1; issue_addr = 6;
    tick(); clear_inputs(); #2;
    n_checks++; if (rd_data_a[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pre_reset_rd got %h want deadbeef", rd_data_a[31:0]); end
    rst_n = 1'b0; #1;
    n_checks++; if (rd_data_a[31:0] !== 32'h0) begin n_fail++; $display("FAIL midreset_rd got %h want 0", rd_data_a[31:0]); end
    n_checks++; if (busy_a !== 32'h0) begin n_fail++; $display("FAIL midreset_busy got %h want 0", busy_a); end
    n_checks++; if (conf_a !== 1'b0) begin n_fail++; $display("FAIL midreset_conf got %b want 0", conf_a); end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_x0();
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'h1234;
    issue_en = 1; issue_addr = 0;
    rd_addr2 = {5'd0, 5'd0}; #2;
    n_checks++; if (rd_data_a !== 64'h0) begin n_fail++; $display("FAIL x0_same got %h want 0", rd_data_a); end
    n_checks++; if (rd_busy_a !== 2'b00) begin n_fail++; $display("FAIL x0_rdbusy got %b want 00", rd_busy_a); end
    tick(); clear_inputs(); #2;
    n_checks++; if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin n_fail++; $display("FAIL x0_next got %h/%h want 0", rd_data_a, rd_data_b); end
    n_checks++; if (busy_a[0] !== 1'b0 || busy_c[0] !== 1'b0) begin n_fail++; $display("FAIL x0_busy got %b/%b want 0", busy_a[0], busy_c[0]); end
    tick();
  endtask

  task automatic test_conflict();
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h22;
    tick(); clear_inputs(); rd_addr2 = {5'd7, 5'd7}; #2;
    n_checks++; if (rd_data_a !== {32'h22, 32'h22}) begin n_fail++; $display("FAIL conflict_data got %h want 22 on both", rd_data_a); end
    n_checks++; if (conf_a !== 1'b1 || conf_c !== 1'b1) begin n_fail++; $display("FAIL conflict_pulse got %b/%b want 1", conf_a, conf_c); end
    tick(); #2;
    n_checks++; if (conf_a !== 1'b0) begin n_fail++; $display("FAIL conflict_width got %b want 0", conf_a); end
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h33;
    wr1_en = 1; wr1_addr = 4; wr1_data = 32'h44;
    tick(); clear_inputs(); rd_addr2 = {5'd4, 5'd3}; #2;
    n_checks++; if (rd_data_a !== {32'h44, 32'h33}) begin n_fail++; $display("FAIL distinct_data got %h want 44/33", rd_data_a); end
    n_checks++; if (conf_a !== 1'b0) begin n_fail++; $display("FAIL distinct_conf got %b want 0", conf_a); end
  endtask

  task automatic test_bypass();
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h55;
    tick(); clear_inputs();
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'hCAFE;
    rd_addr2 = {5'd3, 5'd9}; #2;
    n_checks++; if (rd_data_a[31:0] !== 32'hCAFE) begin n_fail++; $display("FAIL bypass_on got %h want cafe", rd_data_a[31:0]); end
    n_checks++; if (rd_data_b[31:0] !== 32'h55) begin n_fail++; $display("FAIL bypass_off_same got %h want 55", rd_data_b[31:0]); end
    tick(); clear_inputs(); #2;
    n_checks++; if (rd_data_b[31:0] !== 32'hCAFE) begin n_fail++; $display("FAIL bypass_off_next got %h want cafe", rd_data_b[31:0]); end
  endtask

  task automatic test_scoreboard();
    issue_en = 1; issue_addr = 12;
    tick(); clear_inputs(); rd_addr2 = {5'd0, 5'd12}; #2;
    n_checks++; if (busy_a[12] !== 1'b1) begin n_fail++; $display("FAIL sb_set got %b want 1", busy_a[12]); end
    n_checks++; if (rd_busy_a !== 2'b01 || rd_busy_b !== 2'b01) begin n_fail++; $display("FAIL sb_rdbusy got %b/%b want 01", rd_busy_a, rd_busy_b); end
    wr0_en = 1; wr0_addr = 12; wr0_data = 32'h77; #1;
    n_checks++; if (rd_busy_a[0] !== 1'b0 || rd_busy_b[0] !== 1'b1) begin n_fail++; $display("FAIL sb_wb_same got %b/%b want 0/1", rd_busy_a[0], rd_busy_b[0]); end
    tick(); clear_inputs(); #2;
    n_checks++; if (busy_a[12] !== 1'b0) begin n_fail++; $display("FAIL sb_clear got %b want 0", busy_a[12]); end
    issue_en = 1; issue_addr = 12;
    wr0_en = 1; wr0_addr = 12; wr0_data = 32'h78;
    tick(); clear_inputs(); #2;
    n_checks++; if (busy_a[12] !== 1'b1 || busy_c[12] !== 1'b1) begin n_fail++; $display("FAIL sb_issue_wb got %b/%b want 1", busy_a[12], busy_c[12]); end
    wr1_en = 1; wr1_addr = 12; wr1_data = 32'h79;
    tick(); clear_inputs();
  endtask

  task automatic test_wide();
    wr0_en = 1; wr0_addr = 1;  wr0_data = 32'hA1;
    wr1_en = 1; wr1_addr = 2;  wr1_data = 32'hA2;
    tick();
    wr0_addr = 3;  wr0_data = 32'hA3;
    wr1_addr = 15; wr1_data = 32'hAF;
    tick(); clear_inputs();
    rd_addr4 = {5'd15, 5'd3, 5'd2, 5'd1}; #2;
    n_checks++; if (rd_data_c !== {32'hAF, 32'hA3, 32'hA2, 32'hA1}) begin n_fail++; $display("FAIL wide_ports got %h want af/a3/a2/a1", rd_data_c); end
    wr0_en = 1; wr0_addr = 20; wr0_data = 32'hBAD0;
    wr1_en = 1; wr1_addr = 20; wr1_data = 32'hBAD1;
    rd_addr4 = {5'd1, 5'd2, 5'd3, 5'd20}; #2;
    n_checks++; if (rd_data_c[31:0] !== 32'h0) begin n_fail++; $display("FAIL wide_oor_bypass got %h want 0", rd_data_c[31:0]); end
    tick(); clear_inputs(); #2;
    n_checks++; if (rd_data_c[31:0] !== 32'h0) begin n_fail++; $display("FAIL wide_oor_read got %h want 0", rd_data_c[31:0]); end
    n_checks++; if (conf_c !== 1'b0 || conf_a !== 1'b1) begin n_fail++; $display("FAIL wide_oor_conf got %b/%b want 0/1", conf_c, conf_a); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [31:0] eb_a;
      logic [15:0] eb_c;
      wr0_en = ($urandom_range(0, 3) != 0);
      wr1_en = ($urandom_range(0, 2) != 0);
      wr0_addr = 5'($urandom_range(0, 23));
      wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : 5'($urandom_range(0, 23));
      wr0_data = $urandom; wr1_data = $urandom;
      issue_en = ($urandom_range(0, 1) != 0);
      issue_addr = ($urandom_range(0, 4) == 0) ? wr0_addr : 5'($urandom_range(0, 23));
      for (int p = 0; p < 2; p++)
        rd_addr2[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr1_addr : 5'($urandom_range(0, 31));
      for (int p = 0; p < 4; p++)
        rd_addr4[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr0_addr : 5'($urandom_range(0, 23));
      #2;
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (rd_data_a[p*32 +: 32] !== exp_rd(0, 1, rd_addr2[p*5 +: 5]) ||
            rd_busy_a[p] !== exp_busy(0, 1, rd_addr2[p*5 +: 5])) begin
          n_fail++;
          $display("FAIL rand_a cyc %0d port %0d got %h/%b want %h/%b", cyc, p, rd_data_a[p*32 +: 32], rd_busy_a[p],
                   exp_rd(0, 1, rd_addr2[p*5 +: 5]), exp_busy(0, 1, rd_addr2[p*5 +: 5]));
        end
        n_checks++;
        if (rd_data_b[p*32 +: 32] !== exp_rd(0, 0, rd_addr2[p*5 +: 5]) ||
            rd_busy_b[p] !== exp_busy(0, 0, rd_addr2[p*5 +: 5])) begin
          n_fail++;
          $display("FAIL rand_b cyc %0d port %0d got %h/%b want %h/%b", cyc, p, rd_data_b[p*32 +: 32], rd_busy_b[p],
                   exp_rd(0, 0, rd_addr2[p*5 +: 5]), exp_busy(0, 0, rd_addr2[p*5 +: 5]));
        end
      end
      for (int p = 0; p < 4; p++) begin
        n_checks++;
        if (rd_data_c[p*32 +: 32] !== exp_rd(1, 1, rd_addr4[p*5 +: 5]) ||
            rd_busy_c[p] !== exp_busy(1, 1, rd_addr4[p*5 +: 5])) begin
          n_fail++;
          $display("FAIL rand_c cyc %0d port %0d got %h/%b want %h/%b", cyc, p, rd_data_c[p*32 +: 32], rd_busy_c[p],
                   exp_rd(1, 1, rd_addr4[p*5 +: 5]), exp_busy(1, 1, rd_addr4[p*5 +: 5]));
        end
      end
      for (int a = 0; a < 32; a++) eb_a[a] = m_busy[0][a];
      for (int a = 0; a < 16; a++) eb_c[a] = m_busy[1][a];
      n_checks++;
      if (busy_a !== eb_a || busy_b !== eb_a || busy_c !== eb_c) begin
        n_fail++;
        $display("FAIL rand_busy cyc %0d got %h/%h/%h want %h/%h", cyc, busy_a, busy_b, busy_c, eb_a, eb_c);
      end
      n_checks++;
      if (conf_a !== m_conf[0] || conf_b !== m_conf[0] || conf_c !== m_conf[1]) begin
        n_fail++;
        $display("FAIL rand_conf cyc %0d got %b%b%b want %b%b", cyc, conf_a, conf_b, conf_c, m_conf[0], m_conf[1]);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_x0();
    test_conflict();
    test_bypass();
    test_scoreboard();
    test_wide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
